// File: rtl/autosa_pdp_rdma_pkg.sv
// Shared types for the PDP RDMA ping-pong group sequencer: group status codes,
// sequencer states and the default launch gap.
package autosa_pdp_rdma_pkg;

  typedef enum logic [1:0] {
    GRP_IDLE    = 2'd0,
    GRP_RUNNING = 2'd1,
    GRP_PENDING = 2'd2
  } grp_status_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_GAP  = 2'd2
  } fsm_state_e;

  localparam int GAP_CYCLES_DEFAULT = 2;

  // A running group reports RUNNING even though its op_en flag is still set.
  function automatic grp_status_e group_status(input logic running, input logic armed);
    if (running)    return GRP_RUNNING;
    else if (armed) return GRP_PENDING;
    else            return GRP_IDLE;
  endfunction

endpackage

// File: rtl/autosa_pdp_rdma_group_ctrl.sv
// Ping-pong register-group sequencer: arms groups on software op_en writes,
// launches the RDMA datapath on the consumer group and retires it on dp_done.
module autosa_pdp_rdma_group_ctrl
  import autosa_pdp_rdma_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int GAP_W      = 4
) (
  input  logic       autosa_core_clk,
  input  logic       autosa_core_rst,
  input  logic       producer,
  input  logic       op_en_set,
  input  logic       dp_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] op_en,
  output logic       dp_start,
  output logic       dp_group,
  output logic [1:0] done_intr,
  output logic       err_spurious_done
);

  // An oversized gap request clamps to the counter's maximum instead of wrapping.
  localparam int GAP_MAX = (1 << GAP_W) - 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > GAP_MAX) ? GAP_W'(GAP_MAX) : GAP_W'(GAP_CYCLES);

  fsm_state_e        state_reg, state_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic              consumer_reg, consumer_next;
  logic [1:0]        op_en_reg, op_en_next;
  logic              dp_start_reg, dp_start_next;
  logic              dp_group_reg, dp_group_next;
  logic [1:0]        done_intr_reg, done_intr_next;
  logic              err_reg, err_next;
  grp_status_e       status0_reg, status0_next;
  grp_status_e       status1_reg, status1_next;
  logic              set_ok;

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      state_reg     <= FSM_IDLE;
      gap_cnt_reg   <= '0;
      consumer_reg  <= 1'b0;
      op_en_reg     <= 2'b00;
      dp_start_reg  <= 1'b0;
      dp_group_reg  <= 1'b0;
      done_intr_reg <= 2'b00;
      err_reg       <= 1'b0;
      status0_reg   <= GRP_IDLE;
      status1_reg   <= GRP_IDLE;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      consumer_reg  <= consumer_next;
      op_en_reg     <= op_en_next;
      dp_start_reg  <= dp_start_next;
      dp_group_reg  <= dp_group_next;
      done_intr_reg <= done_intr_next;
      err_reg       <= err_next;
      status0_reg   <= status0_next;
      status1_reg   <= status1_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    consumer_next  = consumer_reg;
    op_en_next     = op_en_reg;
    dp_start_next  = 1'b0;
    dp_group_next  = dp_group_reg;
    done_intr_next = 2'b00;
    err_next       = dp_done && (state_reg != FSM_RUN);

    // The running group's registers are locked until it retires.
    set_ok = op_en_set && !((state_reg == FSM_RUN) && (producer == consumer_reg));
    if (set_ok) begin
      op_en_next[producer] = 1'b1;
    end

    case (state_reg)
      FSM_IDLE: begin
        if (op_en_reg[consumer_reg] && (gap_cnt_reg == '0)) begin
          dp_start_next = 1'b1;
          dp_group_next = consumer_reg;
          state_next    = FSM_RUN;
        end
      end
      FSM_RUN: begin
        if (dp_done) begin
          op_en_next[consumer_reg]     = 1'b0;
          done_intr_next[consumer_reg] = 1'b1;
          consumer_next                = ~consumer_reg;
          gap_cnt_next                 = GAP_LOAD;
          state_next                   = (GAP_LOAD == '0) ? FSM_IDLE : FSM_GAP;
        end
      end
      FSM_GAP: begin
        if (gap_cnt_reg <= GAP_W'(1)) begin
          gap_cnt_next = '0;
          state_next   = FSM_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      default: begin
        gap_cnt_next = '0;
        state_next   = FSM_IDLE;
      end
    endcase

    status0_next = group_status((state_next == FSM_RUN) && (consumer_next == 1'b0), op_en_next[0]);
    status1_next = group_status((state_next == FSM_RUN) && (consumer_next == 1'b1), op_en_next[1]);
  end

  assign consumer          = consumer_reg;
  assign status_0          = status0_reg;
  assign status_1          = status1_reg;
  assign op_en             = op_en_reg;
  assign dp_start          = dp_start_reg;
  assign dp_group          = dp_group_reg;
  assign done_intr         = done_intr_reg;
  assign err_spurious_done = err_reg;

endmodule
